reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Ordered reset-release sequencer placed directly after the reset synchronizer. Its `rst` input is the synchronizer's `sync_rst_n` inverted at the parent. It waits for the pixel-clock PLL to report a stable lock, then releases per-stage resets one at a time with a fixed gap: timing generator first, then line buffer, then video output. It re-asserts all stage resets on PLL lock loss or a software reset request, and re-runs the sequence afterwards.

## Interface
- `NUM_STAGES`, default 3: number of sequenced reset outputs. Legal range is 1..8.
- `LOCK_CYCLES`, default 16: number of consecutive locked samples required before release begins. Must be ≥ 1.
- `STAGE_GAP`, default 8: cycles between consecutive stage releases. Must be ≥ 1.
- `SOFT_HOLD`, default 4: minimum number of cycles with `soft_rst_req` low before re-release. Must be ≥ 1.

- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous reset, active-high.
- `pll_locked`, input, 1: PLL lock indication. Already synchronous to `clk`.
- `soft_rst_req`, input, 1: level-sensitive software reset request.
- `stage_rst`, output, NUM_STAGES: per-stage active-high resets. Bit 0 is released first.
- `seq_done`, output, 1: high while every stage is released.
- `lock_lost`, output, 1: one-cycle pulse when lock loss forces re-reset.

## Operation
- All outputs are registered.
- Reset values while `rst` is high: state WAIT_LOCK, counter 0, stage index 0, `stage_rst` all ones, `seq_done` 0, `lock_lost` 0.
- One counter is shared by all states. Its width is `$clog2` of the largest of LOCK_CYCLES, STAGE_GAP and SOFT_HOLD, plus 1. The counter saturates and never wraps.
- WAIT_LOCK:
  - Edge with `pll_locked`=1: counter increments.
  - Edge with `pll_locked`=0: counter clears.
  - On the edge where `pll_locked`=1 and counter = LOCK_CYCLES-1: go to RELEASE, clear counter and stage index.
  - `soft_rst_req` is ignored in this state.
- RELEASE:
  - Counter increments every edge.
  - When counter = STAGE_GAP-1: clear `stage_rst[idx]`, clear counter, increment idx.
  - On the edge that clears bit NUM_STAGES-1: go to RUN and set `seq_done`=1 on that same edge.
- RUN: holds outputs. `stage_rst` is all zeros.
- HOLD:
  - `stage_rst` is all ones.
  - Counter clears while `soft_rst_req`=1 and increments while `soft_rst_req`=0.
  - On the edge where `soft_rst_req`=0 and counter = SOFT_HOLD-1: go to RELEASE, clear counter and idx.
- Lock-loss rule, applies in RELEASE, RUN and HOLD:
  - An edge sampling `pll_locked`=0 sets `stage_rst` to all ones, `seq_done` to 0 and `lock_lost` to 1 for that one cycle.
  - State goes to WAIT_LOCK and the counter clears.
- Soft-request rule, applies in RELEASE and RUN: an edge sampling `soft_rst_req`=1 sets `stage_rst` to all ones and `seq_done` to 0, goes to HOLD and clears the counter.
- Priority: `rst` > lock loss > soft request > normal sequencing.
- Released bits never re-assert individually. Re-assertion always covers all stages on the same edge.
- `stage_rst` bits are monotonic within one sequence: once cleared, a bit stays 0 until a full re-assert.

## Timing
- Let edge E0 be the first edge with `rst`=0 and `pll_locked`=1, with lock held continuously.
  - RELEASE is entered at E(LOCK_CYCLES-1).
  - Stage k is released at E(LOCK_CYCLES-1 + STAGE_GAP·(k+1)).
  - `seq_done` rises with the last stage release.
- Lock loss: `stage_rst` is all ones one cycle after the sampled low. `lock_lost` is high for exactly that cycle.
- A lock glitch in WAIT_LOCK restarts the full LOCK_CYCLES count.
- `rst` asserted mid-sequence: the reset values apply on the next edge regardless of state.
- Simultaneous lock loss and soft request: the lock-loss path is taken and `lock_lost` pulses.

## Test plan
- **Power-up, defaults:** `rst` 1 for 5 cycles, then 0, with `pll_locked` steady at 1 → RELEASE entered at E15; `stage_rst` goes 111→110 at E23, 110→100 at E31, 100→000 at E39; `seq_done`=1 at E39.
- **Lock glitch during WAIT_LOCK:** `pll_locked` low for 1 cycle at E10 → counter restarts; first release occurs 16+8 edges after lock returns.
- **Lock loss in RUN:** drop `pll_locked` for 1 cycle → `stage_rst`=111, `seq_done`=0, `lock_lost` pulses for exactly 1 cycle; full sequence repeats after lock returns.
- **Soft request in RUN, held 10 cycles:** `stage_rst`=111 on the next edge; RELEASE is entered on the 4th edge after the request falls; stage 0 releases 8 edges later.
- **Soft request during RELEASE after stage 0 released:** all bits re-assert; after the hold completes, the sequence restarts from stage 0.
- **Simultaneous `pll_locked`=0 and `soft_rst_req`=1 in RUN:** state goes to WAIT_LOCK (not HOLD), `lock_lost` pulses; also assert `rst` mid-RELEASE → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Ordered reset-release sequencer: waits for a stable PLL lock, then releases
// per-stage resets one at a time; lock loss or a soft request re-asserts them all.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int SOFT_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_done,
  output logic                  lock_lost
);

  localparam int MAX_LG = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
  localparam int MAX_C  = (MAX_LG > SOFT_HOLD) ? MAX_LG : SOFT_HOLD;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam int IW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SOFT_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RELEASE,
    RUN,
    HOLD
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt, cnt_inc;
  logic [IW-1:0]           idx, idx_nxt;
  logic [NUM_STAGES-1:0]   stage_nxt;
  logic                    done_nxt, lost_nxt;

  // Saturating increment shared by every state.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    stage_nxt = stage_rst;
    done_nxt  = seq_done;
    lost_nxt  = 1'b0;

    if (state != WAIT_LOCK && !pll_locked) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
      stage_nxt = '1;
      done_nxt  = 1'b0;
      lost_nxt  = 1'b1;
    end else if ((state == RELEASE || state == RUN) && soft_rst_req) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
      stage_nxt = '1;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (!pll_locked) begin
            cnt_nxt = '0;
          end else if (cnt == LOCK_LAST) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        RELEASE: begin
          if (cnt == GAP_LAST) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
              if (idx == IW'(i)) stage_nxt[i] = 1'b0;
            end
            cnt_nxt = '0;
            idx_nxt = idx + 1'b1;
            if (idx == IDX_LAST) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        HOLD: begin
          if (soft_rst_req) begin
            cnt_nxt = '0;
          end else if (cnt == HOLD_LAST) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      stage_rst <= '1;
      seq_done  <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      stage_rst <= stage_nxt;
      seq_done  <= done_nxt;
      lock_lost <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing checks plus randomized traffic
// compared each cycle against a streak/elapsed-time model of the sequencer.
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int L = 16;
  localparam int G = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pll_locked = 1'b1;
  logic         soft_rst_req = 1'b0;
  logic [N-1:0] stage_rst;
  logic         seq_done;
  logic         lock_lost;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_id = -1;

  reset_sequencer #(
    .NUM_STAGES (N),
    .LOCK_CYCLES(L),
    .STAGE_GAP  (G),
    .SOFT_HOLD  (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .soft_rst_req(soft_rst_req),
    .stage_rst   (stage_rst),
    .seq_done    (seq_done),
    .lock_lost   (lock_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: 0 waiting for lock, 1 sequencing, 2 all released, 3 soft hold.
  int           m_mode = 0;
  int           m_streak, m_elapsed, m_quiet;
  logic [N-1:0] m_rst;
  logic         m_done, m_lost;
  bit           m_valid = 0;

  always @(posedge clk) begin
    m_lost = 1'b0;
    if (rst) begin
      m_mode = 0; m_streak = 0; m_rst = '1; m_done = 0; m_valid = 1;
    end else if (m_mode == 0) begin
      m_streak = pll_locked ? m_streak + 1 : 0;
      if (m_streak == L) begin m_mode = 1; m_elapsed = 0; end
    end else if (!pll_locked) begin
      m_mode = 0; m_streak = 0; m_rst = '1; m_done = 0; m_lost = 1;
    end else if (soft_rst_req && m_mode != 3) begin
      m_mode = 3; m_quiet = 0; m_rst = '1; m_done = 0;
    end else if (m_mode == 1) begin
      m_elapsed++;
      m_rst = {N{1'b1}} << (m_elapsed / G);
      if (m_elapsed / G == N) begin m_mode = 2; m_done = 1; end
    end else if (m_mode == 3) begin
      m_quiet = soft_rst_req ? 0 : m_quiet + 1;
      if (m_quiet == S) begin m_mode = 1; m_elapsed = 0; end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_stage_rst", 32'(stage_rst), 32'(m_rst));
      chk("model_seq_done", 32'(seq_done), 32'(m_done));
      chk("model_lock_lost", 32'(lock_lost), 32'(m_lost));
    end
  end

  // Advance until edge k (counted from the first edge after rst release) has passed.
  task automatic at(input int k);
    while (edge_id < k) begin
      @(posedge clk);
      edge_id++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    edge_id = -1;
  endtask

  bit lock_r;

  initial begin
    // Power-up with lock steady.
    do_reset();
    chk("reset_stage_rst", 32'(stage_rst), 32'h7);
    chk("reset_seq_done", 32'(seq_done), 32'h0);
    chk("reset_lock_lost", 32'(lock_lost), 32'h0);
    at(22); chk("pu_E22", 32'(stage_rst), 32'h7);
    at(23); chk("pu_E23", 32'(stage_rst), 32'h6);
    at(30); chk("pu_E30", 32'(stage_rst), 32'h6);
    at(31); chk("pu_E31", 32'(stage_rst), 32'h4);
    at(38); chk("pu_E38_done", 32'(seq_done), 32'h0);
    at(39); chk("pu_E39", 32'(stage_rst), 32'h0);
    chk("pu_E39_done", 32'(seq_done), 32'h1);

    // Lock glitch at E10 restarts the lock count.
    do_reset();
    at(9);  pll_locked = 1'b0;
    at(10); pll_locked = 1'b1;
    at(33); chk("glitch_E33", 32'(stage_rst), 32'h7);
    at(34); chk("glitch_E34", 32'(stage_rst), 32'h6);

    // Lock loss while running.
    at(60); chk("run_done", 32'(seq_done), 32'h1);
    pll_locked = 1'b0;
    at(61); chk("ll_stage_rst", 32'(stage_rst), 32'h7);
    chk("ll_done", 32'(seq_done), 32'h0);
    chk("ll_pulse", 32'(lock_lost), 32'h1);
    pll_locked = 1'b1;
    at(62); chk("ll_pulse_end", 32'(lock_lost), 32'h0);
    at(84); chk("ll_rerun_E84", 32'(stage_rst), 32'h7);
    at(85); chk("ll_rerun_E85", 32'(stage_rst), 32'h6);

    // Soft request held 10 cycles in RUN.
    at(110); soft_rst_req = 1'b1;
    at(111); chk("soft_assert", 32'(stage_rst), 32'h7);
    at(120); soft_rst_req = 1'b0;
    at(131); chk("soft_E131", 32'(stage_rst), 32'h7);
    at(132); chk("soft_E132", 32'(stage_rst), 32'h6);

    // Soft request during RELEASE after stage 0 released.
    at(134); soft_rst_req = 1'b1;
    at(135); chk("softrel_assert", 32'(stage_rst), 32'h7);
    soft_rst_req = 1'b0;
    at(146); chk("softrel_E146", 32'(stage_rst), 32'h7);
    at(147); chk("softrel_E147", 32'(stage_rst), 32'h6);

    // Simultaneous lock loss and soft request: lock path wins.
    at(170); pll_locked = 1'b0; soft_rst_req = 1'b1;
    at(171); chk("both_pulse", 32'(lock_lost), 32'h1);
    chk("both_stage_rst", 32'(stage_rst), 32'h7);
    pll_locked = 1'b1; soft_rst_req = 1'b0;
    at(183); chk("both_not_hold", 32'(stage_rst), 32'h7);
    at(195); chk("both_relock", 32'(stage_rst), 32'h6);

    // Synchronous reset mid-RELEASE.
    at(198); rst = 1'b1;
    at(199); chk("midrst_stage_rst", 32'(stage_rst), 32'h7);
    chk("midrst_done", 32'(seq_done), 32'h0);
    chk("midrst_lost", 32'(lock_lost), 32'h0);
    rst = 1'b0;

    // Randomized traffic against the model.
    lock_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (lock_r) lock_r = ($urandom_range(0, 79) != 0);
      else        lock_r = ($urandom_range(0, 2) == 0);
      pll_locked = lock_r;
      if ($urandom_range(0, 99) < 2) soft_rst_req = ~soft_rst_req;
      rst = ($urandom_range(0, 799) == 0);
    end

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
